// File: rtl/sha2_pkg.sv
// Shared definitions for the SHA-224/SHA-256 PCPI coprocessor: opcodes, FSM encoding,
// initial hash values, round constants and the SHA-2 mixing functions.
package sha2_pkg;

    // funct3 operation codes
    localparam logic [2:0] F_LW     = 3'b000;
    localparam logic [2:0] F_INIT   = 3'b001;
    localparam logic [2:0] F_NEXT   = 3'b010;
    localparam logic [2:0] F_DIGEST = 3'b011;
    localparam logic [2:0] F_RESET  = 3'b100;
    localparam logic [2:0] F_STATUS = 3'b101;
    localparam logic [2:0] F_MODE   = 3'b110;

    localparam logic MODE_SHA256 = 1'b0;
    localparam logic MODE_SHA224 = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StExec,
        StCoreWait,
        StResp,
        StGuard
    } state_e;

    // H0 sits in the most significant word
    localparam logic [255:0] IV_SHA256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [255:0] IV_SHA224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    localparam logic [31:0] K_TABLE [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] sha2_iv(input logic mode, input int unsigned idx);
        logic [255:0] v;
        v = (mode == MODE_SHA224) ? IV_SHA224 : IV_SHA256;
        return v[255 - 32 * idx -: 32];
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                       input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha256_core.sv
// Iterative SHA-256 compression core, one round per clock. init restarts the chaining
// value from the mode's IV; next chains from the current digest. SHA-224 differs only
// in the IV, the caller truncates the digest.
module sha256_core
    import sha2_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         init,
    input  logic         next,
    input  logic         mode,
    input  logic [511:0] block,
    output logic         ready,
    output logic [255:0] digest
);

    logic [31:0] h_q [8];
    logic [31:0] h_d [8];
    logic [31:0] v_q [8];   // working variables a..h
    logic [31:0] v_d [8];
    logic [31:0] w_q [16];  // message schedule window, w_q[0] is W[t]
    logic [31:0] w_d [16];
    logic [5:0]  round_q, round_d;
    logic        busy_q, busy_d;
    logic [31:0] t1, t2;

    assign ready = !busy_q;

    // Digest packing, H0 in the top word
    always_comb begin
        digest = '0;
        for (int i = 0; i < 8; i++) begin
            digest[255 - 32 * i -: 32] = h_q[i];
        end
    end

    // Start a block or advance one compression round
    always_comb begin
        h_d     = h_q;
        v_d     = v_q;
        w_d     = w_q;
        round_d = round_q;
        busy_d  = busy_q;
        t1      = '0;
        t2      = '0;
        if (init || next) begin
            for (int i = 0; i < 8; i++) begin
                h_d[i] = init ? sha2_iv(mode, i) : h_q[i];
                v_d[i] = init ? sha2_iv(mode, i) : h_q[i];
            end
            for (int i = 0; i < 16; i++) begin
                w_d[i] = block[511 - 32 * i -: 32];
            end
            round_d = '0;
            busy_d  = 1'b1;
        end else if (busy_q) begin
            t1 = v_q[7] + big_sigma1(v_q[4]) + ch(v_q[4], v_q[5], v_q[6]) + K_TABLE[round_q]
                 + w_q[0];
            t2 = big_sigma0(v_q[0]) + maj(v_q[0], v_q[1], v_q[2]);
            v_d[0] = t1 + t2;
            v_d[1] = v_q[0];
            v_d[2] = v_q[1];
            v_d[3] = v_q[2];
            v_d[4] = v_q[3] + t1;
            v_d[5] = v_q[4];
            v_d[6] = v_q[5];
            v_d[7] = v_q[6];
            for (int i = 0; i < 15; i++) begin
                w_d[i] = w_q[i + 1];
            end
            w_d[15] = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];
            round_d = round_q + 6'd1;
            if (round_q == 6'd63) begin
                busy_d = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    h_d[i] = h_q[i] + v_d[i];
                end
            end
        end
    end

    // Core state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) begin
                h_q[i] <= '0;
                v_q[i] <= '0;
            end
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= '0;
            end
            round_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            w_q     <= w_d;
            round_q <= round_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: rtl/picorv32_pcpi_sha2.sv
// PCPI coprocessor exposing SHA-224/SHA-256 through custom-0 instructions: decode,
// handshake FSM, block/status registers and the core-wait timeout around sha256_core.
module picorv32_pcpi_sha2
    import sha2_pkg::*;
#(
    parameter logic [6:0]  OPCODE        = 7'b0001011,
    parameter logic [6:0]  FUNCT7        = 7'b0000000,
    parameter bit          ENABLE_SHA224 = 1'b1,
    parameter bit          BYTE_SWAP     = 1'b0,
    parameter int unsigned CORE_TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready
);

    localparam int unsigned TmoW = $clog2(CORE_TIMEOUT + 1);

    state_e      state_q, state_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] rs1_q, rs1_d;
    logic [31:0] rs2_q, rs2_d;
    logic [31:0] block_q [16];
    logic [31:0] block_d [16];
    logic        digest_valid_q, digest_valid_d;
    logic        error_q, error_d;
    logic        mode_q, mode_d;
    logic        nextok_q, nextok_d;
    logic        core_busy_q, core_busy_d;  // a core run whose result is still owed
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic        wr_q, wr_d;
    logic [31:0] rd_q, rd_d;
    logic        wait_q, wait_d;
    logic        ready_q, ready_d;

    logic         hit;
    logic [31:0]  lw_data;
    logic         core_init, core_next, core_ready;
    logic [511:0] core_block;
    logic [255:0] core_digest;
    logic         unused_insn;

    assign unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

    assign pcpi_wr    = wr_q;
    assign pcpi_rd    = rd_q;
    assign pcpi_wait  = wait_q;
    assign pcpi_ready = ready_q;

    // Instruction decode and load-data formatting
    always_comb begin
        hit = pcpi_valid && (pcpi_insn[6:0] == OPCODE) && (pcpi_insn[31:25] == FUNCT7)
              && (pcpi_insn[14:12] != 3'b111);
        lw_data = rs1_q;
        if (BYTE_SWAP) begin
            lw_data = {rs1_q[7:0], rs1_q[15:8], rs1_q[23:16], rs1_q[31:24]};
        end
        core_block = '0;
        for (int i = 0; i < 16; i++) begin
            core_block[511 - 32 * i -: 32] = block_q[i];
        end
    end

    // Handshake FSM, operation execution and next-state of all registers
    always_comb begin
        state_d        = state_q;
        f3_d           = f3_q;
        rs1_d          = rs1_q;
        rs2_d          = rs2_q;
        block_d        = block_q;
        digest_valid_d = digest_valid_q;
        error_d        = error_q;
        mode_d         = mode_q;
        nextok_d       = nextok_q;
        core_busy_d    = core_busy_q;
        tmo_d          = tmo_q;
        wr_d           = 1'b0;
        rd_d           = rd_q;
        core_init      = 1'b0;
        core_next      = 1'b0;

        // A run finishes even if the CPU gave up waiting for it
        if (core_busy_q && core_ready) begin
            digest_valid_d = 1'b1;
            core_busy_d    = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (hit) begin
                    f3_d    = pcpi_insn[14:12];
                    rs1_d   = pcpi_rs1;
                    rs2_d   = pcpi_rs2;
                    tmo_d   = '0;
                    state_d = StExec;
                end
            end
            StExec: begin
                if (!pcpi_valid) begin
                    state_d = StGuard;
                end else begin
                    state_d = StResp;
                    case (f3_q)
                        F_LW: begin
                            if (rs2_q[31:4] != '0) begin
                                error_d = 1'b1;
                            end else begin
                                block_d[rs2_q[3:0]] = lw_data;
                            end
                        end
                        F_INIT: begin
                            core_init   = 1'b1;
                            core_busy_d = 1'b1;
                            nextok_d    = 1'b1;
                            state_d     = StCoreWait;
                        end
                        F_NEXT: begin
                            if (!nextok_q) begin
                                error_d = 1'b1;
                            end else begin
                                core_next   = 1'b1;
                                core_busy_d = 1'b1;
                                state_d     = StCoreWait;
                            end
                        end
                        F_DIGEST: begin
                            wr_d = 1'b1;
                            if (!digest_valid_q || (rs2_q[31:3] != '0)
                                || ((mode_q == MODE_SHA224) && (rs2_q[2:0] == 3'd7))) begin
                                rd_d    = '0;
                                error_d = 1'b1;
                            end else begin
                                rd_d = core_digest[255 - 32 * int'(rs2_q[2:0]) -: 32];
                            end
                        end
                        F_RESET: begin
                            for (int i = 0; i < 16; i++) begin
                                block_d[i] = '0;
                            end
                            digest_valid_d = 1'b0;
                            error_d        = 1'b0;
                            nextok_d       = 1'b0;
                            core_busy_d    = 1'b0;
                            mode_d         = MODE_SHA256;
                        end
                        F_STATUS: begin
                            wr_d    = 1'b1;
                            rd_d    = {27'b0, nextok_q, error_q, mode_q, digest_valid_q, 1'b1};
                            error_d = 1'b0;
                        end
                        F_MODE: begin
                            if (ENABLE_SHA224) begin
                                mode_d         = rs1_q[0];
                                digest_valid_d = 1'b0;
                            end else begin
                                error_d = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            StCoreWait: begin
                if (!pcpi_valid) begin
                    state_d = StGuard;
                end else if (core_ready) begin
                    state_d = StResp;
                end else if (tmo_q == TmoW'(CORE_TIMEOUT - 1)) begin
                    error_d = 1'b1;
                    state_d = StResp;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StResp:  state_d = StGuard;
            // CPU is still dropping valid for the finished instruction
            StGuard: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        ready_d = (state_d == StResp);
        wait_d  = (state_d == StExec) || (state_d == StCoreWait);
        if (!ready_d) begin
            wr_d = 1'b0;
        end
    end

    // Register update
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            f3_q           <= '0;
            rs1_q          <= '0;
            rs2_q          <= '0;
            for (int i = 0; i < 16; i++) begin
                block_q[i] <= '0;
            end
            digest_valid_q <= 1'b0;
            error_q        <= 1'b0;
            mode_q         <= MODE_SHA256;
            nextok_q       <= 1'b0;
            core_busy_q    <= 1'b0;
            tmo_q          <= '0;
            wr_q           <= 1'b0;
            rd_q           <= '0;
            wait_q         <= 1'b0;
            ready_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            f3_q           <= f3_d;
            rs1_q          <= rs1_d;
            rs2_q          <= rs2_d;
            block_q        <= block_d;
            digest_valid_q <= digest_valid_d;
            error_q        <= error_d;
            mode_q         <= mode_d;
            nextok_q       <= nextok_d;
            core_busy_q    <= core_busy_d;
            tmo_q          <= tmo_d;
            wr_q           <= wr_d;
            rd_q           <= rd_d;
            wait_q         <= wait_d;
            ready_q        <= ready_d;
        end
    end

    sha256_core u_core (
        .clk     (clk),
        .reset_n (reset_n),
        .init    (core_init),
        .next    (core_next),
        .mode    (mode_q),
        .block   (core_block),
        .ready   (core_ready),
        .digest  (core_digest)
    );

endmodule
